aes_key_expand: RTL and testbench
=================================

AES_KEY_EXPAND -- requirements
Module: aes_key_expand

Interface
REQ-001 Parameter: ENABLE_256, default 1, 1 = AES-128 and AES-256 supported, 0 = AES-128 only (keylen ignored, 11-entry storage).
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  synchronous, active-low reset.
REQ-004 Port: key  input  256  cipher key; AES-128 uses key[255:128]; AES-256 uses all 256 bits.
REQ-005 Port: keylen  input  1  0 = AES-128 (10 rounds), 1 = AES-256 (14 rounds); sampled with init.
REQ-006 Port: init  input  1  start-expansion request, level sampled each edge.
REQ-007 Port: round  input  4  round-key read index.
REQ-008 Port: round_key  output  128  combinational read of stored round key[round].
REQ-009 Port: ready  output  1  registered; 1 = idle and round-key storage valid or cleared.
REQ-010 Port: sboxw  output  32  word sent to external 4-byte S-box.
REQ-011 Port: new_sboxw  input  32  combinational SubWord(sboxw) from external S-box.

Function
REQ-012 FSM states: IDLE, INIT, GENERATE; encoding free.
REQ-013 IDLE: init=1 at edge t -> capture key and keylen (keylen forced 0 if ENABLE_256=0), ready<=0, state<=INIT; init=0 -> remain IDLE.
REQ-014 init while state is INIT or GENERATE SHALL be ignored; captured key/keylen are not changed.
REQ-015 INIT (edge t+1): store rk[0]=key[255:128]; if AES-256, also rk[1]=key[127:0]; rcon<=0x01; next index<=1 (AES-128) or 2 (AES-256); state<=GENERATE.
REQ-016 GENERATE: exactly one round key stored per cycle at index i, with prev=rk[i-1], prev2=rk[i-1] (AES-128) or rk[i-2] (AES-256).
REQ-017 Rotate step (all AES-128 rounds; even i in AES-256): sboxw=RotWord(prev.w3), t=new_sboxw^{rcon,24'h0}; rcon<=xtime(rcon) (0x80 -> 0x1b).
REQ-018 Non-rotate step (odd i in AES-256): sboxw=prev.w3, t=new_sboxw; rcon unchanged.
REQ-019 New key: w0=prev2.w0^t, w1=prev2.w1^w0, w2=prev2.w2^w1, w3=prev2.w3^w2; w0 occupies bits [127:96].
REQ-020 Final index 10 (AES-128) or 14 (AES-256): on that store edge ready<=1, state<=IDLE.
REQ-021 Latency: init sampled at edge t -> ready high after edge t+11 (AES-128) or t+14 (AES-256).
REQ-022 sboxw SHALL be 32'h0 outside GENERATE.
REQ-023 round_key = rk[round] when round <= last index of captured keylen; otherwise 128'h0 (indices 11-15 for AES-128, 15 for AES-256).
REQ-024 round_key reads during expansion return current storage contents; only values read with ready=1 are guaranteed.
REQ-025 A new init after completion SHALL fully overwrite storage; AES-128 after AES-256 leaves rk[11..14] unreadable per REQ-023.

Reset
REQ-026 reset=0 at an edge: state<=IDLE, ready<=1, all rk<=0, rcon<=0, captured keylen<=0; takes priority over init and any in-progress expansion.
REQ-027 Reset asserted mid-GENERATE aborts; round_key reads 0 for every index afterwards until a new expansion completes.

Verification
REQ-028 AES-128: key[255:128]=000102030405060708090a0b0c0d0e0f, keylen=0, init pulse -> ready high after 11 cycles; round 1 = d6aa74fdd2af72fadaa678f1d6ab76fe, round 10 = 13111d7fe3944a17f307a78b4d2b30c5.
REQ-029 AES-256: key=000102...1e1f, keylen=1 -> ready after 14 cycles; round 1 = 101112131415161718191a1b1c1d1e1f, round 2 = a573c29fa176c498a97fce93a572c09c, round 14 = 24fc79ccbf0979e9371ac23c6d68de36.
REQ-030 Out-of-range read: after the AES-128 run, round=11 and round=15 -> round_key = 0; after the AES-256 run, round=15 -> 0.
REQ-031 Busy init: pulse init with a different key during GENERATE -> ignored; results equal the original vector.
REQ-032 Mid-run reset: assert reset at cycle 5 of an AES-256 expansion -> ready=1 next cycle, round_key=0 for all indices; a new AES-128 run then matches REQ-028.
REQ-033 Parameter sweep: ENABLE_256=0 with keylen=1 -> behaves as AES-128 and matches REQ-028.

Source files
------------

// File: rtl/aes_key_expand.sv
// AES-128/AES-256 round-key expansion, one round key per cycle.
// SubWord is done by an external 4-byte S-box via sboxw/new_sboxw.
module aes_key_expand #(
  parameter int ENABLE_256 = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [255:0] key,
  input  logic         keylen,
  input  logic         init,
  input  logic [3:0]   round,
  output logic [127:0] round_key,
  output logic         ready,
  output logic [31:0]  sboxw,
  input  logic [31:0]  new_sboxw
);

  localparam int NK = (ENABLE_256 != 0) ? 15 : 11;

  typedef enum logic [1:0] {
    IDLE,
    INIT,
    GENERATE
  } state_e;

  state_e         state_q, state_d;
  logic           ready_q, ready_d;
  logic           keylen_q, keylen_d;
  logic [255:0]   key_q, key_d;
  logic [7:0]     rcon_q, rcon_d;
  logic [3:0]     idx_q, idx_d;
  logic [127:0]   rk_q [NK];
  logic [127:0]   rk_d [NK];

  logic [127:0]   prev, prev_2, prev2;
  logic [127:0]   new_key;
  logic [31:0]    t;
  logic           rot;
  logic [3:0]     last;

  assign last  = keylen_q ? 4'd14 : 4'd10;
  assign ready = ready_q;

  always_comb begin
    prev   = '0;
    prev_2 = '0;
    for (int k = 0; k < NK; k++) begin
      if (4'(k) == idx_q - 4'd1) prev   = rk_q[k];
      if (4'(k) == idx_q - 4'd2) prev_2 = rk_q[k];
    end
    prev2 = keylen_q ? prev_2 : prev;
    // AES-256 odd rounds use plain SubWord without rotate or rcon
    rot   = !keylen_q || !idx_q[0];
    sboxw = '0;
    if (state_q == GENERATE)
      sboxw = rot ? {prev[23:0], prev[31:24]} : prev[31:0];
    t = rot ? (new_sboxw ^ {rcon_q, 24'h0}) : new_sboxw;
    new_key[127:96] = prev2[127:96] ^ t;
    new_key[95:64]  = prev2[95:64]  ^ new_key[127:96];
    new_key[63:32]  = prev2[63:32]  ^ new_key[95:64];
    new_key[31:0]   = prev2[31:0]   ^ new_key[63:32];
  end

  always_comb begin
    round_key = '0;
    for (int k = 0; k < NK; k++)
      if (4'(k) == round && round <= last)
        round_key = rk_q[k];
  end

  always_comb begin
    state_d  = state_q;
    ready_d  = ready_q;
    keylen_d = keylen_q;
    key_d    = key_q;
    rcon_d   = rcon_q;
    idx_d    = idx_q;
    rk_d     = rk_q;
    unique case (state_q)
      IDLE: begin
        if (init) begin
          key_d    = key;
          keylen_d = (ENABLE_256 != 0) ? keylen : 1'b0;
          ready_d  = 1'b0;
          state_d  = INIT;
        end
      end
      INIT: begin
        rk_d[0] = key_q[255:128];
        if (keylen_q) rk_d[1] = key_q[127:0];
        rcon_d  = 8'h01;
        idx_d   = keylen_q ? 4'd2 : 4'd1;
        state_d = GENERATE;
      end
      GENERATE: begin
        for (int k = 0; k < NK; k++)
          if (4'(k) == idx_q) rk_d[k] = new_key;
        if (rot)
          rcon_d = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
        idx_d = idx_q + 4'd1;
        if (idx_q == last) begin
          ready_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      ready_q  <= 1'b1;
      keylen_q <= 1'b0;
      key_q    <= '0;
      rcon_q   <= '0;
      idx_q    <= '0;
      for (int k = 0; k < NK; k++) rk_q[k] <= '0;
    end else begin
      state_q  <= state_d;
      ready_q  <= ready_d;
      keylen_q <= keylen_d;
      key_q    <= key_d;
      rcon_q   <= rcon_d;
      idx_q    <= idx_d;
      for (int k = 0; k < NK; k++) rk_q[k] <= rk_d[k];
    end
  end

endmodule

// File: tb/tb_aes_key_expand.sv
// Scoreboard bench for aes_key_expand: FIPS-197 vectors, latency,
// out-of-range reads, busy init, mid-run reset, ENABLE_256=0 build.
module tb_aes_key_expand;

  logic         clk = 1'b0;
  logic         reset;
  logic [255:0] key;
  logic         keylen;
  logic         init;
  logic [3:0]   round;
  logic [127:0] rk_a, rk_b;
  logic         rdy_a, rdy_b;
  logic [31:0]  sw_a, sw_b, nsw_a, nsw_b;
  logic         rd_req;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit           sel;
    bit           kind;
    logic [3:0]   r;
    logic [127:0] exp;
  } sb_t;
  sb_t sb[$];

  localparam logic [255:0] K128 =
    {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] K128_HI =
    {128'h000102030405060708090a0b0c0d0e0f,
     128'h101112131415161718191a1b1c1d1e1f};
  localparam logic [255:0] K256 = K128_HI;
  localparam logic [127:0] A128_R1  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
  localparam logic [127:0] A128_R10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] A256_R1  = 128'h101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] A256_R2  = 128'ha573c29fa176c498a97fce93a572c09c;
  localparam logic [127:0] A256_R14 = 128'h24fc79ccbf0979e9371ac23c6d68de36;

  aes_key_expand #(.ENABLE_256(1)) dut_a (
    .clk(clk), .reset(reset), .key(key), .keylen(keylen),
    .init(init), .round(round), .round_key(rk_a), .ready(rdy_a),
    .sboxw(sw_a), .new_sboxw(nsw_a)
  );

  aes_key_expand #(.ENABLE_256(0)) dut_b (
    .clk(clk), .reset(reset), .key(key), .keylen(keylen),
    .init(init), .round(round), .round_key(rk_b), .ready(rdy_b),
    .sboxw(sw_b), .new_sboxw(nsw_b)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] gmul(input logic [7:0] a,
                                      input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] v);
    logic [7:0] r = 8'h01;
    logic [7:0] b = v;
    logic [7:0] e = 8'd254;
    logic [7:0] s;
    for (int i = 0; i < 8; i++) begin
      if (e[i]) r = gmul(r, b);
      b = gmul(b, b);
    end
    s = r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]}
          ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    return s;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  always_comb nsw_a = sub_word(sw_a);
  always_comb nsw_b = sub_word(sw_b);

  always @(negedge clk) begin
    if (rd_req) begin
      sb_t          e;
      logic [127:0] act;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty got read with no expectation");
      end else begin
        e = sb.pop_front();
        if (e.kind)
          act = {127'b0, e.sel ? rdy_b : rdy_a};
        else
          act = e.sel ? rk_b : rk_a;
        if (act !== e.exp) begin
          errors++;
          $display("FAIL %s dut%0d round=%0d got %h want %h",
                   e.kind ? "ready" : "round_key", e.sel, e.r,
                   act, e.exp);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input bit sel, input bit kind,
                     input logic [3:0] r, input logic [127:0] exp);
    sb.push_back('{sel, kind, r, exp});
    round  = r;
    rd_req = 1'b1;
    @(negedge clk);
    #1;
    rd_req = 1'b0;
  endtask

  task automatic run(input logic [255:0] k, input logic kl,
                     input bit sel, input int lat, input int busy);
    key    = k;
    keylen = kl;
    init   = 1'b1;
    tick();
    init = 1'b0;
    for (int n = 1; n < lat; n++) begin
      if (n == busy) begin
        key    = ~k;
        keylen = ~kl;
        init   = 1'b1;
      end
      tick();
      init = 1'b0;
    end
    chk(sel, 1'b1, 4'd0, 128'd0);
    tick();
    chk(sel, 1'b1, 4'd0, 128'd1);
  endtask

  initial begin
    reset  = 1'b0;
    init   = 1'b0;
    key    = '0;
    keylen = 1'b0;
    round  = '0;
    rd_req = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    chk(1'b0, 1'b1, 4'd0, 128'd1);
    chk(1'b1, 1'b1, 4'd0, 128'd1);
    chk(1'b0, 1'b0, 4'd0, 128'd0);
    chk(1'b0, 1'b0, 4'd3, 128'd0);

    tick();
    run(K128, 1'b0, 1'b0, 11, 0);
    chk(1'b0, 1'b0, 4'd0,  K128[255:128]);
    chk(1'b0, 1'b0, 4'd1,  A128_R1);
    chk(1'b0, 1'b0, 4'd10, A128_R10);
    chk(1'b0, 1'b0, 4'd11, 128'd0);
    chk(1'b0, 1'b0, 4'd15, 128'd0);
    chk(1'b1, 1'b0, 4'd10, A128_R10);

    tick();
    run(K256, 1'b1, 1'b0, 14, 0);
    chk(1'b0, 1'b0, 4'd0,  K256[255:128]);
    chk(1'b0, 1'b0, 4'd1,  A256_R1);
    chk(1'b0, 1'b0, 4'd2,  A256_R2);
    chk(1'b0, 1'b0, 4'd14, A256_R14);
    chk(1'b0, 1'b0, 4'd15, 128'd0);

    tick();
    run(K128, 1'b0, 1'b0, 11, 3);
    chk(1'b0, 1'b0, 4'd1,  A128_R1);
    chk(1'b0, 1'b0, 4'd10, A128_R10);
    chk(1'b0, 1'b0, 4'd11, 128'd0);
    chk(1'b0, 1'b0, 4'd14, 128'd0);

    tick();
    key    = K256;
    keylen = 1'b1;
    init   = 1'b1;
    tick();
    init = 1'b0;
    for (int n = 1; n < 5; n++) tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk(1'b0, 1'b1, 4'd0, 128'd1);
    for (int r = 0; r < 16; r++)
      chk(1'b0, 1'b0, 4'(r), 128'd0);
    tick();
    run(K128, 1'b0, 1'b0, 11, 0);
    chk(1'b0, 1'b0, 4'd1,  A128_R1);
    chk(1'b0, 1'b0, 4'd10, A128_R10);

    tick();
    run(K128_HI, 1'b1, 1'b1, 11, 0);
    chk(1'b1, 1'b0, 4'd0,  K128_HI[255:128]);
    chk(1'b1, 1'b0, 4'd1,  A128_R1);
    chk(1'b1, 1'b0, 4'd10, A128_R10);
    chk(1'b1, 1'b0, 4'd11, 128'd0);
    chk(1'b1, 1'b0, 4'd15, 128'd0);

    tick();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d left want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
